hazard_ctrl: RTL

Pipeline hazard and sequencing controller for the 5-stage RV32I core. It tracks the destination register of every in-flight instruction in ID/EX, EX/MEM and MEM/WB, and generates the per-stage stall, bubble and flush controls. It produces a registered forwarding select for each EX operand and issues the PC redirect when EX resolves a taken branch or a jump. It sits beside the pipeline registers and is the only block that decides whether a stage advances.

---
 rtl/rv32i_pkg.sv | 19 +
 rtl/hazard_match.sv | 13 +
 rtl/hazard_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared types and constants for the RV32I pipeline control blocks.
package rv32i_pkg;

    // Forwarding select encodings for the EX operand muxes.
    localparam logic [1:0] FWD_RF    = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    // Hazard-relevant summary of one in-flight instruction.
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       wb_en;
        logic       is_load;
    } stage_tag_t;

    localparam stage_tag_t TAG_BUBBLE = '{valid: 1'b0, rd: 5'd0, wb_en: 1'b0, is_load: 1'b0};

endpackage

// File: rtl/hazard_match.sv
// Combinational writer match: does one pipeline slot write the given register?
// Register x0 never matches because writes to it are discarded.
module hazard_match (
    input  logic       i_valid,
    input  logic       i_wb_en,
    input  logic [4:0] i_rd,
    input  logic [4:0] i_reg,
    output logic       o_match
);

    assign o_match = i_valid && i_wb_en && (i_rd == i_reg) && (i_reg != 5'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline.
// Tracks the destination of every in-flight instruction in a three-slot shadow
// (IDEX, EXMEM, MEMWB), generates stall/bubble/flush/redirect controls and a
// registered forwarding select for each EX operand.
//
// Handshake: there is no valid/ready pair here; the pipeline registers sample
// the combinational controls on the same rising edge, and a stage advances
// exactly when its stall output is 0 at that edge.
module hazard_ctrl
    import rv32i_pkg::*;
#(
    parameter int FWD_W = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_wb_enable,
    input  logic             id_is_load,
    input  logic             ex_jmp,
    input  logic             ex_is_branch,
    input  logic             ex_comp_true,
    input  logic             mem_busy,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             flush_if_id,
    output logic             bubble_id_ex,
    output logic             pc_redirect,
    output logic [FWD_W-1:0] fwd_sel_rs1,
    output logic [FWD_W-1:0] fwd_sel_rs2,
    output logic [CNT_W-1:0] cnt_loaduse,
    output logic [CNT_W-1:0] cnt_flush,
    output logic [23:0]      dbg_shadow
);

    stage_tag_t       r_idex;
    stage_tag_t       r_exmem;
    stage_tag_t       r_memwb;
    logic [FWD_W-1:0] r_fwd_rs1;
    logic [FWD_W-1:0] r_fwd_rs2;
    logic [CNT_W-1:0] r_cnt_loaduse;
    logic [CNT_W-1:0] r_cnt_flush;

    logic             w_m_idex_rs1;
    logic             w_m_idex_rs2;
    logic             w_m_exmem_rs1;
    logic             w_m_exmem_rs2;
    logic             w_redirect_cond;
    logic             w_loaduse_cond;
    logic             w_hold;
    logic             w_redirect;
    logic             w_loaduse;
    stage_tag_t       w_id_tag;
    stage_tag_t       w_next_idex;
    logic [FWD_W-1:0] w_fwd_rs1_nxt;
    logic [FWD_W-1:0] w_fwd_rs2_nxt;

    // Writer matches: the two younger slots against both ID sources.
    hazard_match u_m_idex_rs1 (
        .i_valid(r_idex.valid),  .i_wb_en(r_idex.wb_en),  .i_rd(r_idex.rd),
        .i_reg(id_rs1), .o_match(w_m_idex_rs1)
    );
    hazard_match u_m_idex_rs2 (
        .i_valid(r_idex.valid),  .i_wb_en(r_idex.wb_en),  .i_rd(r_idex.rd),
        .i_reg(id_rs2), .o_match(w_m_idex_rs2)
    );
    hazard_match u_m_exmem_rs1 (
        .i_valid(r_exmem.valid), .i_wb_en(r_exmem.wb_en), .i_rd(r_exmem.rd),
        .i_reg(id_rs1), .o_match(w_m_exmem_rs1)
    );
    hazard_match u_m_exmem_rs2 (
        .i_valid(r_exmem.valid), .i_wb_en(r_exmem.wb_en), .i_rd(r_exmem.rd),
        .i_reg(id_rs2), .o_match(w_m_exmem_rs2)
    );

    assign w_redirect_cond = r_idex.valid && (ex_jmp || (ex_is_branch && ex_comp_true));
    assign w_loaduse_cond  = id_valid && r_idex.is_load &&
                             ((id_uses_rs1 && w_m_idex_rs1) || (id_uses_rs2 && w_m_idex_rs2));

    // Priority decision: reset gates everything, then memory hold, redirect, load-use.
    always_comb begin
        w_hold     = 1'b0;
        w_redirect = 1'b0;
        w_loaduse  = 1'b0;
        if (reset) begin
            w_hold = 1'b0;
        end else if (mem_busy) begin
            w_hold = 1'b1;
        end else if (w_redirect_cond) begin
            w_redirect = 1'b1;
        end else if (w_loaduse_cond) begin
            w_loaduse = 1'b1;
        end
    end

    assign stall_pc     = w_hold | w_loaduse;
    assign stall_if_id  = w_hold | w_loaduse;
    assign stall_id_ex  = w_hold;
    assign stall_ex_mem = w_hold;
    assign flush_if_id  = w_redirect;
    assign bubble_id_ex = w_redirect | w_loaduse;
    assign pc_redirect  = w_redirect;

    // Next IDEX contents and forwarding selects for the instruction entering EX.
    always_comb begin
        w_id_tag       = '{valid: id_valid, rd: id_rd, wb_en: id_wb_enable, is_load: id_is_load};
        w_next_idex    = (w_redirect || w_loaduse) ? TAG_BUBBLE : w_id_tag;
        w_fwd_rs1_nxt  = FWD_W'(FWD_RF);
        w_fwd_rs2_nxt  = FWD_W'(FWD_RF);
        if (w_next_idex.valid) begin
            if (id_uses_rs1 && w_m_idex_rs1) begin
                w_fwd_rs1_nxt = FWD_W'(FWD_EXMEM);
            end else if (id_uses_rs1 && w_m_exmem_rs1) begin
                w_fwd_rs1_nxt = FWD_W'(FWD_MEMWB);
            end
            if (id_uses_rs2 && w_m_idex_rs2) begin
                w_fwd_rs2_nxt = FWD_W'(FWD_EXMEM);
            end else if (id_uses_rs2 && w_m_exmem_rs2) begin
                w_fwd_rs2_nxt = FWD_W'(FWD_MEMWB);
            end
        end
    end

    // Shadow slots and forwarding selects advance together unless memory holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idex    <= TAG_BUBBLE;
            r_exmem   <= TAG_BUBBLE;
            r_memwb   <= TAG_BUBBLE;
            r_fwd_rs1 <= '0;
            r_fwd_rs2 <= '0;
        end else if (!w_hold) begin
            r_idex    <= w_next_idex;
            r_exmem   <= r_idex;
            r_memwb   <= r_exmem;
            r_fwd_rs1 <= w_fwd_rs1_nxt;
            r_fwd_rs2 <= w_fwd_rs2_nxt;
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt_loaduse <= '0;
            r_cnt_flush   <= '0;
        end else begin
            if (w_loaduse && (r_cnt_loaduse != '1)) begin
                r_cnt_loaduse <= r_cnt_loaduse + CNT_W'(1);
            end
            if (w_redirect && (r_cnt_flush != '1)) begin
                r_cnt_flush <= r_cnt_flush + CNT_W'(1);
            end
        end
    end

    assign fwd_sel_rs1 = r_fwd_rs1;
    assign fwd_sel_rs2 = r_fwd_rs2;
    assign cnt_loaduse = r_cnt_loaduse;
    assign cnt_flush   = r_cnt_flush;
    assign dbg_shadow  = {r_memwb, r_exmem, r_idex};

endmodule
